// File: rtl/plic_gateway.sv
// plic_gateway: synchronises device interrupt lines and forwards one outstanding request per source to the PLIC core.
// Optional macro PLIC_GW_EDGE_CNT_EN queues edges that arrive while a source is in flight.
module plic_gateway #(
  parameter int NUM_SRC     = 128,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_CNT_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic [NUM_SRC-1:0] src_edge,
  input  logic [NUM_SRC-1:0] int_end,
  output logic [NUM_SRC-1:0] int_req_pack,
  output logic               gateway_notif,
  output logic [NUM_SRC-1:0] src_inflight
);
  typedef enum logic {IDLE, INFLIGHT} state_t;
  if (SYNC_STAGES < 2 || EDGE_CNT_W < 1) begin : g_bad_cfg
    $error("plic_gateway: SYNC_STAGES must be >= 2 and EDGE_CNT_W >= 1");
  end
  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] irq_s, irq_d, req_cond, fwd;
  state_t state [NUM_SRC];
  state_t state_nx [NUM_SRC];
  assign irq_s = sync_q[SYNC_STAGES-1];
  // source 0 is reserved and must never raise a request
  assign req_cond = ((src_edge & irq_s & ~irq_d) | (~src_edge & irq_s)) & ~NUM_SRC'(1);
`ifdef PLIC_GW_EDGE_CNT_EN
  logic [EDGE_CNT_W-1:0] cnt [NUM_SRC];
  logic [EDGE_CNT_W-1:0] cnt_nx [NUM_SRC];
  always_comb begin
    fwd = '0;
    src_inflight = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd[i] = state[i] == IDLE && (req_cond[i] || cnt[i] != '0);
      state_nx[i] = state[i] == INFLIGHT ? (int_end[i] ? IDLE : INFLIGHT) : (fwd[i] ? INFLIGHT : IDLE);
      src_inflight[i] = state[i] == INFLIGHT;
      // a fresh edge in IDLE supplies the forward itself, so only a counter-fed forward drains
      cnt_nx[i] = (state[i] == INFLIGHT && req_cond[i] && src_edge[i] && cnt[i] != '1) ? cnt[i] + EDGE_CNT_W'(1) :
                  (state[i] == IDLE && cnt[i] != '0 && !req_cond[i]) ? cnt[i] - EDGE_CNT_W'(1) : cnt[i];
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_SRC; i++) cnt[i] <= rst ? '0 : cnt_nx[i];
`else
  always_comb begin
    fwd = '0;
    src_inflight = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd[i] = state[i] == IDLE && req_cond[i];
      state_nx[i] = state[i] == INFLIGHT ? (int_end[i] ? IDLE : INFLIGHT) : (fwd[i] ? INFLIGHT : IDLE);
      src_inflight[i] = state[i] == INFLIGHT;
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < NUM_SRC; i++) state[i] <= IDLE;
      irq_d <= '0;
      int_req_pack <= '0;
      gateway_notif <= 1'b0;
    end else begin
      sync_q[0] <= src_irq;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int i = 0; i < NUM_SRC; i++) state[i] <= state_nx[i];
      irq_d <= irq_s;
      int_req_pack <= fwd;
      gateway_notif <= |fwd;
    end
  end
endmodule

// File: tb/tb_plic_gateway.sv
// tb_plic_gateway: directed checks of sync latency, level/edge triggering, completion and reset for plic_gateway.
module tb_plic_gateway;
  localparam int N = 128;
  logic clk = 1'b0, rst = 1'b1, gateway_notif;
  logic [N-1:0] src_irq = '0, src_edge = '0, int_end = '0, int_req_pack, src_inflight;
  logic [N-1:0] m;
  int passes = 0, total = 0, lat, n;
  always #5 clk = ~clk;
  plic_gateway dut (
    .clk(clk), .rst(rst), .src_irq(src_irq), .src_edge(src_edge), .int_end(int_end),
    .int_req_pack(int_req_pack), .gateway_notif(gateway_notif), .src_inflight(src_inflight)
  );
  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic wait_pulse(input string tag, input logic [N-1:0] exp, output int l);
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!gateway_notif && l < 20);
    chk({tag, "_notif"}, N'(gateway_notif), N'(1));
    chk({tag, "_pack"}, int_req_pack, exp);
    @(negedge clk);
    chk({tag, "_width"}, int_req_pack | N'(gateway_notif), '0);
  endtask
  task automatic end_src(input logic [N-1:0] mask);
    int_end = mask;
    @(negedge clk);
    int_end = '0;
  endtask
  task automatic count(input int src, input int win, output int cnt);
    cnt = 0;
    repeat (win) begin
      @(negedge clk);
      if (gateway_notif && int_req_pack[src]) cnt++;
    end
  endtask
  task automatic edges(input int src, input int num, input int per, input int win, output int cnt);
    cnt = 0;
    for (int k = 0; k < win; k++) begin
      src_irq[src] = (k < num * per) && (k % per < per / 2);
      @(negedge clk);
      if (gateway_notif && int_req_pack[src]) cnt++;
    end
  endtask
  initial begin
    src_irq = '1;
    repeat (3) @(negedge clk);
    chk("t1_rst_pack", int_req_pack, '0);
    chk("t1_rst_notif", N'(gateway_notif), '0);
    chk("t1_rst_inflight", src_inflight, '0);
    rst = 1'b0;
    wait_pulse("t1", ~N'(1), lat);
    chk("t1_lat", N'(lat), N'(3));
    chk("t1_bit0", src_inflight & N'(1), '0);
    rst = 1'b1;
    src_irq = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("t1_clear", src_inflight, '0);
    src_irq[5] = 1'b1;
    wait_pulse("t2", N'(1) << 5, lat);
    chk("t2_lat", N'(lat), N'(3));
    chk("t2_inflight", src_inflight, N'(1) << 5);
    count(5, 6, n);
    chk("t2_hold", N'(n), '0);
    end_src(N'(1) << 5);
    wait_pulse("t2_re", N'(1) << 5, lat);
    chk("t2_re_lat", N'(lat), N'(1));
    src_irq[5] = 1'b0;
    count(5, 5, n);
    chk("t2_drop_nopulse", N'(n), '0);
    chk("t2_drop_inflight", src_inflight, N'(1) << 5);
    end_src(N'(1) << 5);
    count(5, 5, n);
    chk("t2_done_nopulse", N'(n), '0);
    chk("t2_done_idle", src_inflight, '0);
    src_edge[40] = 1'b1;
    @(negedge clk);
    edges(40, 3, 6, 20, n);
    chk("t3_first", N'(n), N'(1));
`ifdef PLIC_GW_EDGE_CNT_EN
    end_src(N'(1) << 40);
    count(40, 8, n);
    chk("t3_replay1", N'(n), N'(1));
    end_src(N'(1) << 40);
    count(40, 8, n);
    chk("t3_replay2", N'(n), N'(1));
`else
    end_src(N'(1) << 40);
    count(40, 8, n);
    chk("t3_lost1", N'(n), '0);
    end_src(N'(1) << 40);
    count(40, 8, n);
    chk("t3_lost2", N'(n), '0);
`endif
    end_src(N'(1) << 40);
    count(40, 8, n);
    chk("t3_empty", N'(n), '0);
    chk("t3_idle", src_inflight, '0);
`ifdef PLIC_GW_EDGE_CNT_EN
    src_edge[41] = 1'b1;
    @(negedge clk);
    edges(41, 6, 4, 28, n);
    chk("t4_first", N'(n), N'(1));
    for (int r = 0; r < 3; r++) begin
      end_src(N'(1) << 41);
      count(41, 8, n);
      chk("t4_replay", N'(n), N'(1));
    end
    end_src(N'(1) << 41);
    count(41, 8, n);
    chk("t4_saturated", N'(n), '0);
`endif
    m = (N'(1) << 3) | (N'(1) << 64) | (N'(1) << 127);
    src_irq = src_irq | m;
    wait_pulse("t5", m, lat);
    chk("t5_lat", N'(lat), N'(3));
    chk("t5_inflight", src_inflight, m);
    src_irq = src_irq & ~m;
    repeat (3) @(negedge clk);
    end_src(m);
    chk("t5_idle", src_inflight, '0);
    m = (N'(1) << 7) | (N'(1) << 9);
    src_irq = src_irq | m;
    wait_pulse("t6", m, lat);
    chk("t6_inflight", src_inflight, m);
    rst = 1'b1;
    src_irq[9] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_inflight", src_inflight, '0);
    chk("t6_rst_pack", int_req_pack | N'(gateway_notif), '0);
    wait_pulse("t6_re", N'(1) << 7, lat);
    chk("t6_re_lat", N'(lat), N'(3));
    chk("t6_re_inflight", src_inflight, N'(1) << 7);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
